hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
// - Producer-side companion of the bypass network: tracks in-flight register writes from ID issue to WB retirement.
// - Asserts a pipeline stall when a forwarded value cannot arrive in time:
//   - load-use into EX;
//   - ALU or load result needed by an ID-stage branch/jr compare;
//   - HI/LO access while the multi-cycle mult/div unit is busy.
// - Sits beside ID; drives the PC/IF-ID hold and the ID/EX bubble.
// PARAMETERS
// - MULT_CYCLES  4   mult/multu latency in cycles, >=2
// - DIV_CYCLES   32  div/divu latency in cycles, >=2, <=63
// PORTS
// - clk           in   1  pipeline clock
// - reset         in   1  synchronous, active-high
// - id_valid      in   1  ID holds a real instruction
// - flush         in   1  ID instruction is being squashed this cycle
// - id_rs         in   5  source register A
// - id_rt         in   5  source register B
// - id_rs_used    in   1  rs is read
// - id_rt_used    in   1  rt is read
// - id_branch     in   1  operands consumed in ID (branch compare, jr/jalr)
// - id_reg_write  in   1  instruction writes id_rd
// - id_rd         in   5  destination register
// - id_is_load    in   1  result comes from memory
// - id_mdu_start  in   1  mult/div issue
// - id_mdu_div    in   1  1 = div, 0 = mult; valid with id_mdu_start
// - id_uses_hilo  in   1  mfhi/mflo/mthi/mtlo or mdu start
// - stall         out  1  hold PC and IF/ID; insert bubble into ID/EX
// - mdu_busy      out  1  mult/div in progress
// - mdu_done      out  1  one-cycle pulse on the final mdu cycle
// - stall_count   out  32 stall-cycle count (see CONFIGURATION)
// BEHAVIOUR
// - Issue condition: issue = id_valid & ~flush & ~stall.
// - Reset: all entries cleared; mdu counter 0; stall, mdu_busy, mdu_done and stall_count all 0.
// - Per register r (1..31): age[r] (2 bits, 0 = none pending) and ld[r] (1 bit). Register 0 is never tracked.
//   - Every cycle, each nonzero age increments; at 3 the entry clears to 0 on the next edge (producer retired).
//   - On issue with id_reg_write and id_rd != 0: age[id_rd] <= 1, ld[id_rd] <= id_is_load. A newer write overrides the aging of an older one.
//   - age 1 = producer in EX; age 2 = in MEM; age 3 = in WB.
// - Source stall, for each used source s != 0 with age a = age[s]:
//   - non-branch: stall if ld[s] & a == 1 (load-use, exactly 1 bubble);
//   - branch: stall if a == 1, or if ld[s] & a == 2 (ALU: 1 bubble; load: 2 bubbles).
//   - a == 3, or an entry cleared the same cycle: no stall (WB forward / register-file write-through).
// - MDU:
//   - On issue with id_mdu_start: counter <= MULT_CYCLES or DIV_CYCLES per id_mdu_div; mdu_busy = (counter != 0).
//   - Counter decrements each cycle; mdu_done = (counter == 1).
//   - Stall if id_valid & id_uses_hilo & mdu_busy; this is released in the mdu_done cycle (HI/LO written at that edge).
// - stall is combinational from current state and ID inputs (zero latency) and is forced to 0 when ~id_valid or flush.
// - Stalled cycles do not issue; ages still advance, because the bubble lets producers drain.
// - flush never clears already-issued entries; they are older than the squashed instruction.
// - Reset mid-operation clears all state on that edge, including an in-progress mdu count.
// CONFIGURATION
// - HAZARD_PERF_EN defined: stall_count increments on every cycle with stall == 1; saturates at 32'hFFFFFFFF; cleared by reset.
// - HAZARD_PERF_EN undefined: stall_count tied to 0 and no counter logic.
// TESTING
// - lw $2 issued, then add $3,$2,$4 in ID next cycle -> stall=1 for exactly 1 cycle, then issues.
// - add $2 issued, then beq $2,$0 next cycle -> stall 1 cycle. lw $2 then beq $2 -> stall 2 cycles.
// - lw $2; nop; add $5,$2,$2 -> no stall. Writes or reads of $0 never stall.
// - div issued (DIV_CYCLES=32), then mflo on the next cycle -> stall held; mdu_done pulses once; mflo issues that cycle.
// - flush=1 with a dependent instruction in ID -> stall=0, no entry set. Reset during a div -> mdu_busy=0 on the next cycle.
// - HAZARD_PERF_EN set: the load-use case above plus the 2-cycle branch case -> stall_count == 3.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight register writes and MDU occupancy and raises the ID stall.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard #(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic        flush,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic        id_branch,
    input  logic        id_reg_write,
    input  logic [4:0]  id_rd,
    input  logic        id_is_load,
    input  logic        id_mdu_start,
    input  logic        id_mdu_div,
    input  logic        id_uses_hilo,
    output logic        stall,
    output logic        mdu_busy,
    output logic        mdu_done,
    output logic [31:0] stall_count
);

    localparam int unsigned CNT_W = 6;

    logic [31:0][1:0]  r_age;
    logic [31:0]       r_ld;
    logic [CNT_W-1:0]  r_mdu_cnt;

    logic w_issue;
    logic w_rs_hz;
    logic w_rt_hz;
    logic w_hilo_hz;
    logic w_stall;
    logic w_busy;
    logic w_done;

    // Forwarding window per source: age 1 = EX, 2 = MEM, 3 = WB (always forwardable).
    function automatic logic src_hazard(input logic used, input logic [1:0] age,
                                        input logic ld, input logic br, input logic [4:0] s);
        logic hz;
        hz = 1'b0;
        if (used && s != 5'd0) begin
            if (br)
                hz = (age == 2'd1) || (ld && age == 2'd2);
            else
                hz = ld && (age == 2'd1);
        end
        return hz;
    endfunction

    always_comb begin
        w_busy    = (r_mdu_cnt != '0);
        w_done    = (r_mdu_cnt == CNT_W'(1));
        w_rs_hz   = src_hazard(id_rs_used, r_age[id_rs], r_ld[id_rs], id_branch, id_rs);
        w_rt_hz   = src_hazard(id_rt_used, r_age[id_rt], r_ld[id_rt], id_branch, id_rt);
        // HI/LO are written at the edge ending the done cycle, so that cycle may proceed.
        w_hilo_hz = id_uses_hilo && w_busy && !w_done;
        w_stall   = id_valid && !flush && (w_rs_hz || w_rt_hz || w_hilo_hz);
        w_issue   = id_valid && !flush && !w_stall;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_age     <= '0;
            r_ld      <= '0;
            r_mdu_cnt <= '0;
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (r_age[i] != 2'd0)
                    r_age[i] <= r_age[i] + 2'd1;
            end
            if (w_issue && id_reg_write && id_rd != 5'd0) begin
                r_age[id_rd] <= 2'd1;
                r_ld[id_rd]  <= id_is_load;
            end
            if (w_issue && id_mdu_start)
                r_mdu_cnt <= id_mdu_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            else if (w_busy)
                r_mdu_cnt <= r_mdu_cnt - CNT_W'(1);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (reset)
            r_stall_count <= '0;
        else if (w_stall && r_stall_count != '1)
            r_stall_count <= r_stall_count + 32'd1;
    end

    assign stall_count = r_stall_count;
`else
    assign stall_count = '0;
`endif

    assign stall    = w_stall;
    assign mdu_busy = w_busy;
    assign mdu_done = w_done;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: scripted pipeline sequences with expected
// stall/mdu outputs queued at drive time and compared at the falling edge.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, flush;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_rs_used, id_rt_used, id_branch, id_reg_write, id_is_load;
    logic        id_mdu_start, id_mdu_div, id_uses_hilo;
    logic        stall, mdu_busy, mdu_done;
    logic [31:0] stall_count;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .flush(flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_branch(id_branch), .id_reg_write(id_reg_write), .id_rd(id_rd),
        .id_is_load(id_is_load), .id_mdu_start(id_mdu_start), .id_mdu_div(id_mdu_div),
        .id_uses_hilo(id_uses_hilo), .stall(stall), .mdu_busy(mdu_busy),
        .mdu_done(mdu_done), .stall_count(stall_count)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [2:0]  exp_q[$];
    logic [31:0] exp_cnt = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; flush = 0; id_rs = 0; id_rt = 0; id_rd = 0;
        id_rs_used = 0; id_rt_used = 0; id_branch = 0; id_reg_write = 0; id_is_load = 0;
        id_mdu_start = 0; id_mdu_div = 0; id_uses_hilo = 0;
    endtask

    task automatic ins(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                       input logic rtu, input logic br, input logic rw,
                       input logic [4:0] rd, input logic ld);
        idle();
        id_valid = 1; id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        id_branch = br; id_reg_write = rw; id_rd = rd; id_is_load = ld;
    endtask

    // Inputs are already driven; queue the expectation, compare at negedge, return at posedge+1.
    task automatic tick(input string tag, input logic s, input logic b, input logic d);
        logic [2:0] e;
        exp_q.push_back({s, b, d});
        @(negedge clk);
        e = exp_q.pop_front();
        check({tag, ".stall"}, 32'(stall), 32'(e[2]));
        check({tag, ".busy"}, 32'(mdu_busy), 32'(e[1]));
        check({tag, ".done"}, 32'(mdu_done), 32'(e[0]));
`ifdef HAZARD_PERF_EN
        check({tag, ".cnt"}, stall_count, exp_cnt);
`else
        check({tag, ".cnt"}, stall_count, 32'd0);
`endif
        if (reset) exp_cnt = '0;
        else if (e[2]) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) tick("drain", 0, 0, 0);
    endtask

    initial begin
        reset = 1;
        idle();
        @(posedge clk);
        #1;
        tick("rst", 0, 0, 0);
        reset = 0;

        // lw $2 ; add $3,$2,$4 -> one bubble
        ins(0, 0, 0, 0, 0, 1, 2, 1);  tick("lu_lw", 0, 0, 0);
        ins(2, 4, 1, 1, 0, 1, 3, 0);  tick("lu_add", 1, 0, 0);
        tick("lu_add_go", 0, 0, 0);
        drain();

        // lw $2 ; beq $2,$0 -> two bubbles
        ins(0, 0, 0, 0, 0, 1, 2, 1);  tick("lb_lw", 0, 0, 0);
        ins(2, 0, 1, 1, 1, 0, 0, 0);  tick("lb_beq1", 1, 0, 0);
        tick("lb_beq2", 1, 0, 0);
        tick("lb_go", 0, 0, 0);
        drain();
`ifdef HAZARD_PERF_EN
        check("perf3", stall_count, 32'd3);
`endif

        // add $2 ; beq $2,$0 -> one bubble
        ins(0, 0, 0, 0, 0, 1, 2, 0);  tick("ab_add", 0, 0, 0);
        ins(2, 0, 1, 1, 1, 0, 0, 0);  tick("ab_beq", 1, 0, 0);
        tick("ab_go", 0, 0, 0);
        drain();

        // lw $2 ; nop ; add $5,$2,$2 -> no stall
        ins(0, 0, 0, 0, 0, 1, 2, 1);  tick("gap_lw", 0, 0, 0);
        ins(0, 0, 0, 0, 0, 0, 0, 0);  tick("gap_nop", 0, 0, 0);
        ins(2, 2, 1, 1, 0, 1, 5, 0);  tick("gap_add", 0, 0, 0);
        drain();

        // $0 never tracked; unused source never stalls
        ins(0, 0, 0, 0, 0, 1, 0, 1);  tick("z_lw0", 0, 0, 0);
        ins(0, 0, 1, 1, 0, 0, 0, 0);  tick("z_use0", 0, 0, 0);
        ins(0, 0, 1, 1, 1, 0, 0, 0);  tick("z_br0", 0, 0, 0);
        ins(0, 0, 0, 0, 0, 1, 2, 1);  tick("un_lw", 0, 0, 0);
        ins(2, 2, 0, 0, 0, 0, 0, 0);  tick("un_use", 0, 0, 0);
        drain();

        // flush squashes the stall and the squashed write
        ins(0, 0, 0, 0, 0, 1, 2, 1);  tick("fl_lw", 0, 0, 0);
        ins(2, 4, 1, 1, 0, 1, 7, 1);  flush = 1;  tick("fl_dep", 0, 0, 0);
        ins(7, 0, 1, 0, 0, 0, 0, 0);  tick("fl_no7", 0, 0, 0);
        ins(0, 0, 0, 0, 0, 1, 2, 1);  tick("iv_lw", 0, 0, 0);
        ins(2, 4, 1, 1, 0, 0, 0, 0);  id_valid = 0;  tick("iv_dep", 0, 0, 0);
        drain();

        // stalled load issues only when released, then its own consumer stalls
        ins(0, 0, 0, 0, 0, 1, 2, 1);  tick("ch_lw2", 0, 0, 0);
        ins(2, 0, 1, 0, 0, 1, 3, 1);  tick("ch_lw3_st", 1, 0, 0);
        tick("ch_lw3_go", 0, 0, 0);
        ins(3, 0, 1, 0, 0, 0, 0, 0);  tick("ch_use3_st", 1, 0, 0);
        tick("ch_use3_go", 0, 0, 0);
        drain();

        // newer load overrides older ALU write
        ins(0, 0, 0, 0, 0, 1, 2, 0);  tick("ov_add", 0, 0, 0);
        ins(0, 0, 0, 0, 0, 1, 2, 1);  tick("ov_lw", 0, 0, 0);
        ins(2, 0, 1, 0, 0, 0, 0, 0);  tick("ov_use", 1, 0, 0);
        tick("ov_go", 0, 0, 0);
        drain();

        // mult then mfhi: 3 stalls, released in the done cycle
        ins(0, 0, 0, 0, 0, 0, 0, 0);  id_mdu_start = 1; id_uses_hilo = 1;
        tick("mul_iss", 0, 0, 0);
        ins(0, 0, 0, 0, 0, 0, 0, 0);  id_uses_hilo = 1;
        for (int i = 0; i < 3; i++) tick("mul_wait", 1, 1, 0);
        tick("mul_done", 0, 1, 1);
        idle();  tick("mul_idle", 0, 0, 0);

        // div then mflo: 31 stalls, released in the done cycle
        ins(0, 0, 0, 0, 0, 0, 0, 0);  id_mdu_start = 1; id_mdu_div = 1; id_uses_hilo = 1;
        tick("div_iss", 0, 0, 0);
        ins(0, 0, 0, 0, 0, 0, 0, 0);  id_uses_hilo = 1;
        for (int i = 0; i < 31; i++) tick("div_wait", 1, 1, 0);
        tick("div_done", 0, 1, 1);
        idle();  tick("div_idle", 0, 0, 0);

        // reset during a div clears the count
        ins(0, 0, 0, 0, 0, 0, 0, 0);  id_mdu_start = 1; id_mdu_div = 1; id_uses_hilo = 1;
        tick("rd_iss", 0, 0, 0);
        idle();  tick("rd_busy", 0, 1, 0);
        reset = 1;  tick("rd_rst", 0, 1, 0);
        reset = 0;  tick("rd_after", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
